// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, window offset helper and FSM states for conv3x3_window_gen
// Optional macro WIN_STRIDE2_EN selects stride-2 window generation.
package conv_pkg;

  localparam int IMG_W     = 416;
  localparam int PIX_W     = 8;
  localparam int PAD_W     = IMG_W + 2;
  localparam int WIN_ELEMS = 9;
  localparam int ROW_W     = PAD_W * PIX_W;
  localparam int WIN_W     = WIN_ELEMS * PIX_W;
  localparam int COL_W     = $clog2(IMG_W);

`ifdef WIN_STRIDE2_EN
  localparam int WIN_STEP = 2;
`else
  localparam int WIN_STEP = 1;
`endif

  localparam int N_WIN = IMG_W / WIN_STEP;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  // Bit offset of window element (r,c) in a packed 3x3 window bus.
  function automatic int win_off(input int r, input int c);
    return (r * 3 + c) * PIX_W;
  endfunction

endpackage

// File: rtl/win_shift_chan.sv
// rtl/win_shift_chan.sv - one colour: three padded-row shift registers and the registered 3x3 window tap
module win_shift_chan
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             fill,
  input  logic             adv,
  input  logic [ROW_W-1:0] row0,
  input  logic [ROW_W-1:0] row1,
  input  logic [ROW_W-1:0] row2,
  output logic [WIN_W-1:0] win
);

  logic [ROW_W-1:0] sr [3];
  logic [WIN_W-1:0] tap_fill;
  logic [WIN_W-1:0] tap_adv;

  // Pixel 0 of each shift register is always the left edge of the current window.
  always_comb begin
    tap_fill = '0;
    tap_adv  = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tap_fill[win_off(r, c) +: PIX_W] = sr[r][c * PIX_W +: PIX_W];
        tap_adv[win_off(r, c) +: PIX_W]  = sr[r][(c + WIN_STEP) * PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sr[0] <= row0;
      sr[1] <= row1;
      sr[2] <= row2;
    end else if (adv) begin
      for (int r = 0; r < 3; r++) begin
        sr[r] <= sr[r] >> (WIN_STEP * PIX_W);
      end
    end

    if (reset) begin
      win <= '0;
    end else if (fill) begin
      win <= tap_fill;
    end else if (adv) begin
      win <= tap_adv;
    end
  end

endmodule

// File: rtl/conv3x3_window_gen.sv
// rtl/conv3x3_window_gen.sv - 3x3 window generator over padded RGB row triples
// Optional macro WIN_STRIDE2_EN (in conv_pkg) selects stride 2.
module conv3x3_window_gen
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic [ROW_W-1:0] R_row0,
  input  logic [ROW_W-1:0] G_row0,
  input  logic [ROW_W-1:0] B_row0,
  input  logic [ROW_W-1:0] R_row1,
  input  logic [ROW_W-1:0] G_row1,
  input  logic [ROW_W-1:0] B_row1,
  input  logic [ROW_W-1:0] R_row2,
  input  logic [ROW_W-1:0] G_row2,
  input  logic [ROW_W-1:0] B_row2,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [WIN_W-1:0] R_win,
  output logic [WIN_W-1:0] G_win,
  output logic [WIN_W-1:0] B_win,
  output logic [COL_W-1:0] win_col,
  output logic             win_last
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_WIN - 1);

  state_t           state, state_n;
  logic             row_ready_n;
  logic             win_valid_n;
  logic [COL_W-1:0] col_n;
  logic             load, fill, adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row_ready <= 1'b0;
      win_valid <= 1'b0;
      win_col   <= '0;
    end else begin
      state     <= state_n;
      row_ready <= row_ready_n;
      win_valid <= win_valid_n;
      win_col   <= col_n;
    end
  end

  always_comb begin
    state_n     = state;
    row_ready_n = row_ready;
    win_valid_n = win_valid;
    col_n       = win_col;
    load        = 1'b0;
    fill        = 1'b0;
    adv         = 1'b0;
    if (en && !reset) begin
      case (state)
        IDLE: begin
          row_ready_n = 1'b1;
          if (row_valid && row_ready) begin
            load        = 1'b1;
            col_n       = '0;
            row_ready_n = 1'b0;
            state_n     = FILL;
          end
        end
        FILL: begin
          fill        = 1'b1;
          win_valid_n = 1'b1;
          state_n     = STREAM;
        end
        STREAM: begin
          if (win_valid && win_ready) begin
            if (win_col == LAST_COL) begin
              // Raise row_ready on the way out so the next triple can land in the IDLE cycle.
              win_valid_n = 1'b0;
              row_ready_n = 1'b1;
              state_n     = IDLE;
            end else begin
              adv   = 1'b1;
              col_n = win_col + COL_W'(1);
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign win_last = win_valid && (win_col == LAST_COL);

  win_shift_chan u_r (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .fill (fill),
    .adv  (adv),
    .row0 (R_row0),
    .row1 (R_row1),
    .row2 (R_row2),
    .win  (R_win)
  );

  win_shift_chan u_g (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .fill (fill),
    .adv  (adv),
    .row0 (G_row0),
    .row1 (G_row1),
    .row2 (G_row2),
    .win  (G_win)
  );

  win_shift_chan u_b (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .fill (fill),
    .adv  (adv),
    .row0 (B_row0),
    .row1 (B_row1),
    .row2 (B_row2),
    .win  (B_win)
  );

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// tb/tb_conv3x3_window_gen.sv - scoreboard bench for conv3x3_window_gen
module tb_conv3x3_window_gen;

  localparam int IMG_W = 416;
  localparam int PIX_W = 8;
  localparam int PAD_W = IMG_W + 2;
  localparam int ROW_W = PAD_W * PIX_W;
  localparam int WIN_W = 9 * PIX_W;
  localparam int COL_W = $clog2(IMG_W);
`ifdef WIN_STRIDE2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int NWIN = IMG_W / STEP;

  typedef struct {
    logic [WIN_W-1:0] r;
    logic [WIN_W-1:0] g;
    logic [WIN_W-1:0] b;
    logic [COL_W-1:0] col;
    logic             last;
  } win_t;

  logic             clk = 1'b0;
  logic             reset, en, row_valid, win_ready;
  logic             row_ready, win_valid, win_last;
  logic [ROW_W-1:0] rr [3];
  logic [ROW_W-1:0] gr [3];
  logic [ROW_W-1:0] br [3];
  logic [WIN_W-1:0] R_win, G_win, B_win;
  logic [COL_W-1:0] win_col;

  int   n_checks = 0;
  int   n_errors = 0;
  win_t q[$];
  win_t e;
  int   cur_mode = 0;
  int   pop_cnt = 0;
  int   lat = -1;
  bit   last_seen = 0;
  bit   held = 0;
  logic [WIN_W-1:0] h_r, h_g, h_b;
  logic [COL_W-1:0] h_col;
  logic             h_last;

  always #5 clk = ~clk;

  conv3x3_window_gen dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .R_row0   (rr[0]),
    .G_row0   (gr[0]),
    .B_row0   (br[0]),
    .R_row1   (rr[1]),
    .G_row1   (gr[1]),
    .B_row1   (br[1]),
    .R_row2   (rr[2]),
    .G_row2   (gr[2]),
    .B_row2   (br[2]),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .R_win    (R_win),
    .G_win    (G_win),
    .B_win    (B_win),
    .win_col  (win_col),
    .win_last (win_last)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // mode 0: ramp r*100+p (+40 per colour); mode 1: 0x55 with zero pads.
  function automatic logic [PIX_W-1:0] pix(input int mode, input int color, input int r, input int p);
    if (mode == 0) return PIX_W'((r * 100 + p + color * 40) % 256);
    return (p == 0 || p == PAD_W - 1) ? 8'h00 : 8'h55;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      held      = 0;
      lat       = -1;
      last_seen = 0;
    end else begin
      if (held) begin
        check("stall_R", R_win, h_r);
        check("stall_G", G_win, h_g);
        check("stall_B", B_win, h_b);
        check("stall_col", win_col, h_col);
        check("stall_last", win_last, h_last);
        check("stall_valid", win_valid, 1'b1);
      end
      if (last_seen) begin
        check("ready_after_last", row_ready, 1'b1);
        check("valid_after_last", win_valid, 1'b0);
        last_seen = 0;
      end
      if (lat == 0) begin
        check("lat_fill", win_valid, 1'b0);
        lat = 1;
      end else if (lat == 1) begin
        check("lat_first", win_valid, 1'b1);
        lat = -1;
      end
      if (en && win_valid && win_ready) begin
        if (q.size() == 0) begin
          check("spurious_win", win_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("win_R", R_win, e.r);
          check("win_G", G_win, e.g);
          check("win_B", B_win, e.b);
          check("win_col", win_col, e.col);
          check("win_last", win_last, e.last);
          pop_cnt++;
          if (e.last) last_seen = 1;
        end
      end
      if (en && row_valid && row_ready) begin
        for (int k = 0; k < NWIN; k++) begin
          win_t w;
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
              w.r[(r * 3 + c) * PIX_W +: PIX_W] = pix(cur_mode, 0, r, k * STEP + c);
              w.g[(r * 3 + c) * PIX_W +: PIX_W] = pix(cur_mode, 1, r, k * STEP + c);
              w.b[(r * 3 + c) * PIX_W +: PIX_W] = pix(cur_mode, 2, r, k * STEP + c);
            end
          end
          w.col  = COL_W'(k);
          w.last = (k == NWIN - 1);
          q.push_back(w);
        end
        pop_cnt = 0;
        lat     = 0;
      end
      held   = win_valid && !(en && win_ready);
      h_r    = R_win;
      h_g    = G_win;
      h_b    = B_win;
      h_col  = win_col;
      h_last = win_last;
    end
  end

  task automatic send_row(input int mode);
    bit got = 0;
    cur_mode = mode;
    for (int p = 0; p < PAD_W; p++) begin
      for (int r = 0; r < 3; r++) begin
        rr[r][p * PIX_W +: PIX_W] = pix(mode, 0, r, p);
        gr[r][p * PIX_W +: PIX_W] = pix(mode, 1, r, p);
        br[r][p * PIX_W +: PIX_W] = pix(mode, 2, r, p);
      end
    end
    row_valid = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (row_ready && en && !reset) got = 1;
    end
    check("row_accept_timeout", got, 1'b1);
    @(posedge clk);
    #1;
    row_valid = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rr[r] = '0;
      gr[r] = '1;
      br[r] = '0;
    end
  endtask

  task automatic drain(input bit toggle, output int cycles);
    bit done = 0;
    cycles = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      win_ready = toggle ? ~win_ready : 1'b1;
      if (q.size() == 0 && !win_valid && row_ready) done = 1;
    end
    check("drain_timeout", done, 1'b1);
    win_ready = 1'b1;
  endtask

  task automatic wait_pops(input int n);
    bit got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (pop_cnt >= n) got = 1;
    end
    check("pop_wait_timeout", got, 1'b1);
  endtask

  initial begin
    int cyc;
    reset     = 1'b1;
    en        = 1'b1;
    row_valid = 1'b0;
    win_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      rr[r] = '0;
      gr[r] = '0;
      br[r] = '0;
    end
    @(posedge clk);
    #1;
    check("rst_row_ready", row_ready, 1'b0);
    check("rst_win_valid", win_valid, 1'b0);
    check("rst_R_win", R_win, '0);
    check("rst_G_win", G_win, '0);
    check("rst_B_win", B_win, '0);
    check("rst_win_col", win_col, '0);
    check("rst_win_last", win_last, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_row_ready", row_ready, 1'b1);
    check("idle_win_valid", win_valid, 1'b0);

    // Ramp, always ready: one window per cycle.
    send_row(0);
    drain(1'b0, cyc);
    check("throughput_ramp", cyc, NWIN + 1);

    // Ramp under alternating backpressure.
    win_ready = 1'b0;
    send_row(0);
    drain(1'b1, cyc);

    // Padding edges.
    send_row(1);
    drain(1'b0, cyc);
    check("throughput_pad", cyc, NWIN + 1);

    // Mid-row reset.
    send_row(0);
    wait_pops(100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_win_valid", win_valid, 1'b0);
    check("midrst_row_ready", row_ready, 1'b0);
    check("midrst_R_win", R_win, '0);
    check("midrst_win_col", win_col, '0);
    reset = 1'b0;
    send_row(0);
    drain(1'b0, cyc);

    // Enable gating mid-stream.
    send_row(0);
    wait_pops(NWIN / 2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("en_freeze_valid", win_valid, 1'b1);
      check("en_freeze_col", win_col, q.size() > 0 ? q[0].col : '1);
    end
    en = 1'b1;
    drain(1'b0, cyc);
    check("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_window_gen.md
Name: conv3x3_window_gen

Overview:
- Consumes the three padded 418-pixel rows (R/G/B) produced by the padding stage.
- Emits one 3x3 window per output column for each colour to the convolution PE array over a valid/ready handshake.
- Per accepted row triple, it produces IMG_W windows left to right, then requests the next triple.
- Sits directly downstream of padding_top and upstream of the 3x3 MAC stage.

Parameters:
- IMG_W, 416, unpadded image width in pixels; padded width PAD_W = IMG_W+2.
- PIX_W, 8, bits per pixel.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  global enable; 0 freezes all state and outputs.
- row_valid  in  1  row triple on R/G/B_row0..2 is valid.
- row_ready  out  1  block can latch a row triple.
- R_row0, G_row0, B_row0  in  PAD_W*PIX_W  top padded row; pixel p at bits [p*PIX_W +: PIX_W], p=0 is left pad.
- R_row1, G_row1, B_row1  in  PAD_W*PIX_W  middle padded row, same layout.
- R_row2, G_row2, B_row2  in  PAD_W*PIX_W  bottom padded row, same layout.
- win_valid  out  1  window outputs valid.
- win_ready  in  1  consumer accepts the window.
- R_win, G_win, B_win  out  9*PIX_W  element (r,c) at bits [(r*3+c)*PIX_W +: PIX_W]; r = row 0..2, c = column offset 0..2.
- win_col  out  clog2(IMG_W)  output column index of the current window.
- win_last  out  1  current window is the last of the row triple.

Behaviour:
- Reset values: row_ready=0, win_valid=0, R/G/B_win=0, win_col=0, win_last=0; FSM goes to IDLE.
- row_ready is registered and goes to 1 one cycle after reset deasserts.
- FSM states:
  - IDLE: row_ready=1. On row_valid&&row_ready&&en, latch all nine row buses into shift registers, col=0, go to FILL.
  - FILL: one cycle. Loads window column 0 (padded pixels 0..2) into the output registers, win_valid=1, go to STREAM.
  - STREAM: on win_valid&&win_ready&&en:
    - if win_col==IMG_W-1: win_valid=0, go to IDLE.
    - else: shift all rows right by one pixel, load the window for col+1, win_col+=1.
- Latency: first win_valid is 2 cycles after the row handshake cycle. Steady state is 1 window/cycle with win_ready held high.
- Row throughput: IMG_W+2 cycles per row triple (accept + fill + IMG_W windows), with a 1-cycle IDLE bubble.
- Window content for col k, element (r,c): padded pixel k+c of row r.
- Stall rule: while win_valid && !win_ready, all outputs stay bit-stable.
- win_last = (win_col==IMG_W-1) && win_valid.
- row_ready is 0 outside IDLE; row_valid there is ignored and the inputs need not be held.
- en=0 in any state: no state change, no handshake counted on either side (even if valid/ready are high), outputs held.
- reset asserted mid-row: remaining windows are discarded and all reset values apply on the next edge.
- No arithmetic is performed; pixels pass through unmodified.

Optional Feature:
- Macro WIN_STRIDE2_EN.
- Defined: stride 2.
  - Windows for cols 0,2,4,...,IMG_W-2 (IMG_W/2 windows).
  - Shift by two pixels per accept.
  - win_col reports the output index 0..IMG_W/2-1.
  - win_last at output index IMG_W/2-1.
- Undefined: stride 1 as above.
- Handshake and timing rules are otherwise identical.

Decomposition:
- Shared package conv_pkg holds:
  - IMG_W, PIX_W, PAD_W constants.
  - WIN_ELEMS=9.
  - A window-element offset function (r,c) -> bit offset.
  - The FSM state enum {IDLE, FILL, STREAM}.
- One natural sub-module, win_shift_chan: 3-row shift register plus 3x3 window tap for a single colour. Instantiated three times (R, G, B); FSM and counter stay in the top.

Test Plan:
1. Reset then idle: reset=1 for 1 cycle -> all outputs 0. Next cycle row_ready=1, win_valid=0.
2. Ramp row: row r pixel p = r*100+p (mod 256) on all colours, win_ready=1.
   - 416 consecutive windows.
   - Window k element (r,c) = r*100+k+c.
   - win_last only at k=415; row_ready returns 1 one cycle later.
3. Backpressure: toggle win_ready 1/0 every cycle. Window sequence is identical to test 2, and outputs are stable during every stall cycle.
4. Padding edges: rows all 0x55 except pixels 0 and 417 = 0x00.
   - Window 0 column c=0 = 0x00.
   - Window 415 column c=2 = 0x00.
   - All other elements = 0x55.
5. Mid-row reset and en gating: reset at window 100 -> outputs cleared; the next accepted triple starts at win_col=0. en=0 for 5 cycles mid-stream -> win_col frozen, no window lost or duplicated.
6. WIN_STRIDE2_EN with the ramp from test 2: 208 windows, window k element (r,c) = r*100+2k+c; win_last at k=207.
